// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: operand/control bus between the execute stage and the iterative multiply/divide unit
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] src_A;
  logic [WIDTH-1:0] src_B;
  logic [3:0]       ALU_control;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] remainder;
  logic             zero;
  logic             div_by_zero;
  modport master (output start, src_A, src_B, ALU_control,
                  input busy, done, result, remainder, zero, div_by_zero);
  modport slave (input start, src_A, src_B, ALU_control,
                 output busy, done, result, remainder, zero, div_by_zero);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned shift-add multiplier and restoring divider sharing one accumulator
module muldiv_unit #(parameter int WIDTH = 32) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mul_step, div_step;
  logic [WIDTH-1:0]   opnd_q, result_q, remainder_q;
  logic               div_q, dz_q, divz_q, is_div, accept, finish;
  logic [WIDTH:0]     sum, sh, diff;
  assign is_div = bus.ALU_control == 4'b0011;
  assign accept = bus.start && (bus.ALU_control == 4'b0010 || is_div) && state_q != RUN;
  assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_step = {sum, acc_q[WIDTH-1:1]};
  assign sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign diff = sh - {1'b0, opnd_q};
  assign div_step = {diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0], acc_q[WIDTH-2:0], ~diff[WIDTH]};
  assign finish = state_q == RUN && (dz_q || cnt_q == LAST);
  assign bus.busy = state_q == RUN;
  assign bus.done = state_q == DONE;
  assign bus.result = result_q;
  assign bus.remainder = remainder_q;
  assign bus.zero = result_q == '0;
  assign bus.div_by_zero = divz_q;
  // next state, one iteration step per RUN cycle, and request acceptance from IDLE or DONE
  always_comb begin
    state_d = state_q == DONE ? IDLE : (finish ? DONE : state_q);
    cnt_d = state_q == RUN ? cnt_q + 1'b1 : cnt_q;
    acc_d = state_q == RUN && !dz_q ? (div_q ? div_step : mul_step) : acc_q;
    if (accept) begin
      state_d = RUN;
      cnt_d = '0;
      acc_d = {{WIDTH{1'b0}}, is_div ? bus.src_A : bus.src_B};
    end
  end
  // state and datapath registers; visible results change only when DONE is entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      opnd_q <= '0;
      div_q <= 1'b0;
      dz_q <= 1'b0;
      result_q <= '0;
      remainder_q <= '0;
      divz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      if (accept) begin
        opnd_q <= is_div ? bus.src_B : bus.src_A;
        div_q <= is_div;
        dz_q <= is_div && bus.src_B == '0;
      end
      if (finish) begin
        result_q <= dz_q ? '1 : acc_d[WIDTH-1:0];
        remainder_q <= dz_q ? acc_q[WIDTH-1:0] : acc_d[2*WIDTH-1:WIDTH];
        divz_q <= dz_q;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  muldiv_unit_if #(.WIDTH(32)) bus();
  muldiv_unit #(.WIDTH(32)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic [31:0] rem, output logic dbz);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    dbz = 1'b0;
    if (op == 4'b0010) begin
      res = p[31:0];
      rem = p[63:32];
    end else if (b == 0) begin
      res = 32'hFFFF_FFFF;
      rem = a;
      dbz = 1'b1;
    end else begin
      res = a / b;
      rem = a % b;
    end
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.ALU_control = op;
    bus.src_A = a;
    bus.src_B = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.src_A = $urandom;
    bus.src_B = $urandom;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk); #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", bus.done); end
    total++; if (bus.result !== 32'd0) begin bad++; $display("FAIL reset_result got %h want 0", bus.result); end
    total++; if (bus.remainder !== 32'd0) begin bad++; $display("FAIL reset_rem got %h want 0", bus.remainder); end
    total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL reset_zero got %b want 1", bus.zero); end
    total++; if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got %b want 0", bus.div_by_zero); end
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er, em;
    logic ed;
    int lat, bc, el;
    model(op, a, b, er, em, ed);
    el = (op == 4'b0011 && b == 0) ? 1 : 32;
    issue(op, a, b);
    wait_done(lat, bc);
    total++; if (lat != el) begin bad++; $display("FAIL %s_latency got %0d want %0d", name, lat, el); end
    total++; if (bc != el) begin bad++; $display("FAIL %s_busy_cycles got %0d want %0d", name, bc, el); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s_busy_in_done got %b want 0", name, bus.busy); end
    total++; if (bus.result !== er) begin bad++; $display("FAIL %s_result a=%h b=%h got %h want %h", name, a, b, bus.result, er); end
    total++; if (bus.remainder !== em) begin bad++; $display("FAIL %s_remainder a=%h b=%h got %h want %h", name, a, b, bus.remainder, em); end
    total++; if (bus.zero !== (er == 0)) begin bad++; $display("FAIL %s_zero got %b want %b", name, bus.zero, er == 0); end
    total++; if (bus.div_by_zero !== ed) begin bad++; $display("FAIL %s_dbz got %b want %b", name, bus.div_by_zero, ed); end
    @(posedge clk); #1;
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL %s_done_pulse got %b want 0", name, bus.done); end
    total++; if (bus.result !== er) begin bad++; $display("FAIL %s_hold got %h want %h", name, bus.result, er); end
  endtask

  task automatic test_multiply;
    run_op("mul_7x6", 4'b0010, 32'd7, 32'd6);
    run_op("mul_max_x2", 4'b0010, 32'hFFFF_FFFF, 32'd2);
    run_op("mul_max_x_max", 4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_divide;
    run_op("div_100_7", 4'b0011, 32'd100, 32'd7);
    run_op("div_5_9", 4'b0011, 32'd5, 32'd9);
    run_op("div_max_1", 4'b0011, 32'hFFFF_FFFF, 32'd1);
    run_op("div_max_max", 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_div_by_zero;
    run_op("div_by_0", 4'b0011, 32'h1234, 32'd0);
    run_op("mul_after_dz", 4'b0010, 32'd3, 32'd5);
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic [3:0] op;
    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 1) ? 4'b0011 : 4'b0010;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 300);
        2: a = $urandom_range(0, 1000);
        default: ;
      endcase
      run_op("random", op, a, b);
    end
  endtask

  task automatic test_ignored;
    logic [31:0] er, em;
    logic ed;
    int lat, bc;
    model(4'b0011, 32'd1000, 32'd33, er, em, ed);
    issue(4'b0011, 32'd1000, 32'd33);
    repeat (9) begin @(posedge clk); #1; end
    issue(4'b0010, 32'd77, 32'd88);
    wait_done(lat, bc);
    total++; if (lat != 22) begin bad++; $display("FAIL ign_run_latency got %0d want 22", lat); end
    total++; if (bus.result !== er) begin bad++; $display("FAIL ign_run_result got %h want %h", bus.result, er); end
    total++; if (bus.remainder !== em) begin bad++; $display("FAIL ign_run_rem got %h want %h", bus.remainder, em); end
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ign_run_queued got %b want 0", bus.busy); end
    issue(4'b0000, 32'd9, 32'd9);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ign_op0_busy got %b want 0", bus.busy); end
    issue(4'b0111, 32'd9, 32'd9);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ign_op7_busy got %b want 0", bus.busy); end
    total++; if (bus.result !== er) begin bad++; $display("FAIL ign_op_result got %h want %h", bus.result, er); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] er, em;
    logic ed;
    int lat, bc;
    model(4'b0010, 32'd12345, 32'd678, er, em, ed);
    issue(4'b0010, 32'd12345, 32'd678);
    wait_done(lat, bc);
    total++; if (bus.result !== er) begin bad++; $display("FAIL b2b_first_result got %h want %h", bus.result, er); end
    model(4'b0011, 32'd99999, 32'd13, er, em, ed);
    issue(4'b0011, 32'd99999, 32'd13);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got %b want 1", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL b2b_done got %b want 0", bus.done); end
    wait_done(lat, bc);
    total++; if (lat != 32) begin bad++; $display("FAIL b2b_latency got %0d want 32", lat); end
    total++; if (bus.result !== er) begin bad++; $display("FAIL b2b_second_result got %h want %h", bus.result, er); end
    total++; if (bus.remainder !== em) begin bad++; $display("FAIL b2b_second_rem got %h want %h", bus.remainder, em); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int dones;
    issue(4'b0010, 32'd7, 32'd6);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    bus.start = 1'b1;
    bus.ALU_control = 4'b0010;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_mid_done got %b want 0", bus.done); end
    total++; if (bus.result !== 32'd0) begin bad++; $display("FAIL rst_mid_result got %h want 0", bus.result); end
    total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL rst_mid_zero got %b want 1", bus.zero); end
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL rst_mid_activity got %0d want 0", dones); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.ALU_control = 4'b0000;
    bus.src_A = '0;
    bus.src_B = '0;
    test_reset;
    test_multiply;
    test_divide;
    test_div_by_zero;
    test_ignored;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
